// File: rtl/mult_sequencer_if.sv
// Handshake and adder-drive bundle for mult_sequencer.
// The slave modport is the sequencer side; master is the controller plus the external adder.
interface mult_sequencer_if;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] add_opA;
  logic [31:0] add_opB;
  logic [2:0]  add_command;
  logic [31:0] add_ans;
  logic        add_carryout;

  modport master (
    output start, multiplicand, multiplier, add_ans, add_carryout,
    input  busy, done, product, add_opA, add_opB, add_command
  );

  modport slave (
    input  start, multiplicand, multiplier, add_ans, add_carryout,
    output busy, done, product, add_opA, add_opB, add_command
  );
endinterface

// File: rtl/mult_sequencer.sv
// Iterative 32x32 -> 64 unsigned shift-add multiplier that borrows an external 32-bit adder,
// producing one partial-product bit per cycle over 32 RUN cycles.
module mult_sequencer (
  input  logic                  clk,
  input  logic                  reset,
  mult_sequencer_if.slave       bus_io
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] mcand_q;
  logic [4:0]  count_q;
  logic [63:0] product_q;
  logic        busy_q;
  logic        done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            mcand_q <= bus_io.multiplicand;
            lo_q    <= bus_io.multiplier;
            hi_q    <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Shift the 33-bit sum right by one across hi:lo; the dropped lo[0] is consumed.
          hi_q    <= {bus_io.add_carryout, bus_io.add_ans[31:1]};
          lo_q    <= {bus_io.add_ans[0], lo_q[31:1]};
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            product_q <= {bus_io.add_carryout, bus_io.add_ans, lo_q[31:1]};
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.add_opA     = hi_q;
  assign bus_io.add_opB     = lo_q[0] ? mcand_q : 32'h0;
  assign bus_io.add_command = 3'b000;
  assign bus_io.busy        = busy_q;
  assign bus_io.done        = done_q;
  assign bus_io.product     = product_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed vector table, random products against
// plain multiplication, and hand-written handshake corner cases.
module tb_mult_sequencer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  mult_sequencer_if bus ();

  mult_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  // Behavioural adder: add with carry-in 0.
  assign {bus.add_carryout, bus.add_ans} = {1'b0, bus.add_opA} + {1'b0, bus.add_opB};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic        chk_opb0;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Counts edges after the accept edge until done is seen; -1 if the bound expires.
  task automatic wait_done(input bit chk_opb0, input bit chk_hold, input logic [63:0] hold_val,
                           output int edges);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      if (chk_opb0) check("opB_zero_in_run", 64'(bus.add_opB), 64'h0);
      if (chk_hold) check("product_hold", bus.product, hold_val);
      tick();
      if (bus.done === 1'b1) begin
        edges = i;
        break;
      end
    end
    if (edges < 0) check("done_timeout", 64'(1), 64'(0));
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                          input bit chk_opb0, input string name);
    int edges;
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    tick();
    bus.start = 1'b0;
    check({name, "_busy_rise"}, 64'(bus.busy), 64'(1));
    check({name, "_done_low"}, 64'(bus.done), 64'(0));
    wait_done(chk_opb0, 1'b0, 64'h0, edges);
    check({name, "_latency"}, 64'(edges), 64'(32));
    check({name, "_product"}, bus.product, exp);
    tick();
    check({name, "_done_pulse_end"}, 64'(bus.done), 64'(0));
    check({name, "_busy_fall"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    int          edges;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] prev;

    n_cmp            = 0;
    n_fail           = 0;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    tick();
    tick();
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_product", bus.product, 64'h0);
    check("rst_opA", 64'(bus.add_opA), 64'h0);
    check("rst_opB", 64'(bus.add_opB), 64'h0);
    check("add_command", 64'(bus.add_command), 64'h0);
    reset = 1'b0;
    tick();

    vecs[0] = '{32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
    vecs[2] = '{32'h1234_5678, 32'h0, 64'h0, 1'b1};
    vecs[3] = '{32'h1, 32'h8000_0000, 64'h0000_0000_8000_0000, 1'b0};
    vecs[4] = '{32'd7, 32'd6, 64'd42, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_mult(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].chk_opb0, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      ra = $urandom();
      rb = $urandom();
      if (i % 5 == 0) ra = 32'hFFFF_FFFF;
      if (i % 7 == 0) rb = 32'hFFFF_FFFF ^ (32'h1 << (i % 32));
      run_mult(ra, rb, {32'h0, ra} * {32'h0, rb}, 1'b0, $sformatf("rand%0d", i));
    end

    // Start during RUN and DONE is ignored.
    bus.start        = 1'b1;
    bus.multiplicand = 32'd7;
    bus.multiplier   = 32'd6;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus.start        = 1'b1;
    bus.multiplicand = 32'd9;
    bus.multiplier   = 32'd9;
    wait_done(1'b0, 1'b0, 64'h0, edges);
    check("ign_latency", 64'(edges + 10), 64'(32));
    check("ign_product", bus.product, 64'd42);
    tick();
    bus.start = 1'b0;
    check("ign_busy_fall", 64'(bus.busy), 64'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ign_no_restart", 64'({bus.busy, bus.done}), 64'(0));
    end

    // Reset mid-operation abandons the product.
    bus.start        = 1'b1;
    bus.multiplicand = 32'd9;
    bus.multiplier   = 32'd9;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_done", 64'(bus.done), 64'(0));
    check("midrst_product", bus.product, 64'h0);
    for (int i = 0; i < 35; i++) begin
      tick();
      check("midrst_no_done", 64'(bus.done), 64'(0));
    end
    run_mult(32'd2, 32'd2, 64'd4, 1'b0, "after_rst");

    // Back-to-back with start held high; product holds through the second RUN.
    bus.start        = 1'b1;
    bus.multiplicand = 32'd10;
    bus.multiplier   = 32'd10;
    tick();
    bus.multiplicand = 32'd20;
    bus.multiplier   = 32'd20;
    wait_done(1'b0, 1'b0, 64'h0, edges);
    check("b2b_first_latency", 64'(edges), 64'(32));
    check("b2b_first_product", bus.product, 64'd100);
    prev = bus.product;
    tick();
    check("b2b_idle_gap", 64'(bus.busy), 64'(0));
    tick();
    bus.start = 1'b0;
    check("b2b_second_accept", 64'(bus.busy), 64'(1));
    wait_done(1'b0, 1'b1, prev, edges);
    check("b2b_second_latency", 64'(edges), 64'(32));
    check("b2b_second_product", bus.product, 64'd400);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
